// File: rtl/reg_file_dumper_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_dumper_pkg
//   Shared definitions for the register-file dump engine: the FSM state
//   encoding and the default geometry, which matches the 8x8 reg_file.
// ---------------------------------------------------------------------------
package reg_file_dumper_pkg;

    localparam int DEF_NUM_REGS  = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_READ_WAIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND0 = 3'd3,
        ST_SEND1 = 3'd4,
        ST_FIN   = 3'd5
    } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// ---------------------------------------------------------------------------
// reg_file_dumper
//   Read-side initiator that dumps the whole register file on START.
//   Registers are read two at a time through the file's asynchronous read
//   ports while the read-address bus is granted. The values are then streamed
//   out one byte per valid/ready handshake, tagged with their register index.
//   The dumper never writes the file.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   START                 one-cycle pulse, begins a dump when idle
//   BUS_REQ / BUS_GNT     read-port arbitration handshake
//   RD_ADDR1 / RD_ADDR2   read addresses for the pair (2p, 2p+1)
//   RD_DATA1 / RD_DATA2   register-file read data
//   DOUT, DOUT_IDX        streamed value and its register index
//   DOUT_VALID/READY/LAST stream handshake, LAST marks index NUM_REGS-1
//   BUSY                  high whenever not idle
//   DONE                  one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_WAIT = DEF_READ_WAIT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              BUS_REQ,
    input  logic              BUS_GNT,
    output logic [ADDR_W-1:0] RD_ADDR1,
    output logic [ADDR_W-1:0] RD_ADDR2,
    input  logic [DATA_W-1:0] RD_DATA1,
    input  logic [DATA_W-1:0] RD_DATA2,
    output logic [DATA_W-1:0] DOUT,
    output logic [ADDR_W-1:0] DOUT_IDX,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              DOUT_LAST,
    output logic              BUSY,
    output logic              DONE
);

    localparam int WAIT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS / 2 - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_WAIT);

    dump_state_t       state;
    dump_state_t       next_state;
    logic [ADDR_W-1:0] pair;
    logic [ADDR_W-1:0] pair_base;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;

    // Address of the even register of the current pair.
    assign pair_base = pair << 1;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: pair counter, read-settle counter and the two
    // capture buffers. Captures only happen at the end of an unbroken wait,
    // so a grant loss never leaves half-sampled data behind.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pair     <= '0;
            wait_cnt <= '0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (BUS_GNT) begin
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (BUS_GNT) begin
                        if (wait_cnt == '0) begin
                            buf0 <= RD_DATA1;
                            buf1 <= RD_DATA2;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                end
                ST_SEND1: begin
                    if (DOUT_READY && (pair != LAST_PAIR)) begin
                        pair <= pair + 1'b1;
                    end
                end
                ST_FIN: begin
                    pair <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (START) next_state = ST_REQ;
            ST_REQ:   if (BUS_GNT) next_state = ST_WAIT;
            ST_WAIT: begin
                if (!BUS_GNT) begin
                    next_state = ST_REQ;
                end else if (wait_cnt == '0) begin
                    next_state = ST_SEND0;
                end
            end
            ST_SEND0: if (DOUT_READY) next_state = ST_SEND1;
            ST_SEND1: begin
                if (DOUT_READY) begin
                    next_state = (pair == LAST_PAIR) ? ST_FIN : ST_REQ;
                end
            end
            ST_FIN:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so VALID never has a
    // combinational path from READY and the bus is released while sending.
    always_comb begin
        RD_ADDR1   = pair_base;
        RD_ADDR2   = pair_base | ADDR_W'(1);
        BUS_REQ    = 1'b0;
        DOUT       = '0;
        DOUT_IDX   = '0;
        DOUT_VALID = 1'b0;
        DOUT_LAST  = 1'b0;
        BUSY       = (state != ST_IDLE);
        DONE       = 1'b0;
        case (state)
            ST_REQ, ST_WAIT: BUS_REQ = 1'b1;
            ST_SEND0: begin
                DOUT       = buf0;
                DOUT_IDX   = pair_base;
                DOUT_VALID = 1'b1;
            end
            ST_SEND1: begin
                DOUT       = buf1;
                DOUT_IDX   = pair_base | ADDR_W'(1);
                DOUT_VALID = 1'b1;
                DOUT_LAST  = (pair == LAST_PAIR);
            end
            ST_FIN:   DONE = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// ---------------------------------------------------------------------------
// tb_reg_file_dumper
//   Drives reg_file_dumper against a behavioural register file with a
//   2-time-unit asynchronous read delay. Expected bytes come from the model
//   array: the k-th accepted byte of a dump must be register k's value.
// ---------------------------------------------------------------------------
module tb_reg_file_dumper;

    localparam int RW = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic       BUS_REQ;
    logic       BUS_GNT = 1'b1;
    logic [2:0] RD_ADDR1;
    logic [2:0] RD_ADDR2;
    logic [7:0] RD_DATA1;
    logic [7:0] RD_DATA2;
    logic [7:0] DOUT;
    logic [2:0] DOUT_IDX;
    logic       DOUT_VALID;
    logic       DOUT_READY = 1'b1;
    logic       DOUT_LAST;
    logic       BUSY;
    logic       DONE;

    logic [7:0] regs [8];

    int total = 0;
    int bad = 0;
    int exp_idx = 0;
    int bytes = 0;
    int done_count = 0;
    int n;

    reg_file_dumper #(.READ_WAIT(RW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
        .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
        .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
        .DOUT(DOUT), .DOUT_IDX(DOUT_IDX), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Register file model with asynchronous, delayed read ports.
    assign #2 RD_DATA1 = regs[RD_ADDR1];
    assign #2 RD_DATA2 = regs[RD_ADDR2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_bus_req"}, BUS_REQ, 0);
        checkOutput({tag, "_addr1"}, RD_ADDR1, 0);
        checkOutput({tag, "_addr2"}, RD_ADDR2, 1);
        checkOutput({tag, "_dout"}, DOUT, 0);
        checkOutput({tag, "_idx"}, DOUT_IDX, 0);
        checkOutput({tag, "_valid"}, DOUT_VALID, 0);
        checkOutput({tag, "_last"}, DOUT_LAST, 0);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_done"}, DONE, 0);
    endtask

    task automatic clearCounts();
        exp_idx    = 0;
        bytes      = 0;
        done_count = 0;
    endtask

    // Wait for DONE (optionally randomizing grant and ready), then confirm
    // the dump produced exactly eight bytes, one DONE and returned to idle.
    task automatic waitDone(input string tag, input bit rnd);
        int k = 0;
        while (DONE !== 1'b1 && k < 2000) begin
            if (rnd) begin
                BUS_GNT    = ($urandom % 4) != 0;
                DOUT_READY = ($urandom % 3) != 0;
            end
            step();
            k++;
        end
        checkOutput({tag, "_done_seen"}, DONE, 1);
        BUS_GNT    = 1'b1;
        DOUT_READY = 1'b1;
        step();
        checkOutput({tag, "_busy_after"}, BUSY, 0);
        checkOutput({tag, "_byte_count"}, bytes, 8);
        checkOutput({tag, "_done_count"}, done_count, 1);
    endtask

    task automatic waitIdx(input string tag, input logic [2:0] idx);
        int k = 0;
        while (!(DOUT_VALID === 1'b1 && DOUT_IDX === idx) && k < 200) begin
            step();
            k++;
        end
        checkOutput({tag, "_reach_idx"}, DOUT_IDX, idx);
    endtask

    task automatic countToValid(output int cnt);
        cnt = 0;
        while (DOUT_VALID !== 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
    endtask

    // Stream monitor. Inputs change just after posedge, so whatever is seen
    // at negedge is what the next posedge samples.
    bit         pend = 1'b0;
    bit         prev_rst = 1'b0;
    bit         last_acc = 1'b0;
    logic [7:0] prev_dout;
    logic [2:0] prev_idx;

    always @(negedge CLK) begin
        if (pend && !prev_rst) begin
            checkOutput("hold_valid", DOUT_VALID, 1);
            checkOutput("hold_dout", DOUT, prev_dout);
            checkOutput("hold_idx", DOUT_IDX, prev_idx);
        end
        if (DONE === 1'b1) begin
            done_count++;
            checkOutput("done_after_last", last_acc, 1);
        end
        if (DOUT_VALID === 1'b1) begin
            checkOutput("bus_released", BUS_REQ, 0);
        end
        last_acc = 1'b0;
        if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b1 && RESET === 1'b0) begin
            checkOutput("stream_idx", DOUT_IDX, exp_idx[2:0]);
            checkOutput("stream_data", DOUT, regs[exp_idx[2:0]]);
            checkOutput("stream_last", DOUT_LAST, exp_idx == 7);
            last_acc = (exp_idx == 7);
            exp_idx++;
            bytes++;
        end
        pend      = DOUT_VALID && !DOUT_READY;
        prev_dout = DOUT;
        prev_idx  = DOUT_IDX;
        prev_rst  = RESET;
    end

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h11 * i);

        // Reset state.
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        checkResetOutputs("reset");

        // Basic dump with grant and ready tied high, including latency.
        clearCounts();
        applyStimulus();
        checkOutput("t1_busy", BUSY, 1);
        checkOutput("t1_bus_req", BUS_REQ, 1);
        countToValid(n);
        checkOutput("t1_latency", n, 2 + RW);
        checkOutput("t1_first_byte", DOUT, 8'h00);
        waitDone("t1", 1'b0);
        checkResetOutputs("t1_idle");

        // Back-pressure for five cycles on index 3.
        clearCounts();
        applyStimulus();
        waitIdx("t2", 3'd3);
        DOUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t2_held_dout", DOUT, 8'h33);
            checkOutput("t2_held_idx", DOUT_IDX, 3);
        end
        DOUT_READY = 1'b1;
        waitDone("t2", 1'b0);

        // Grant withheld for four cycles at the start.
        clearCounts();
        BUS_GNT = 1'b0;
        applyStimulus();
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t3_req_held", BUS_REQ, 1);
            checkOutput("t3_no_valid", DOUT_VALID, 0);
        end
        BUS_GNT = 1'b1;
        countToValid(n);
        checkOutput("t3_latency", n, 1 + RW + 1);
        waitDone("t3", 1'b0);

        // Grant dropped mid-wait on pair 2; the pair is re-read afterwards.
        clearCounts();
        applyStimulus();
        n = 0;
        while (!(RD_ADDR1 === 3'd4 && BUS_REQ === 1'b1) && n < 200) begin
            step();
            n++;
        end
        checkOutput("t4_reach_pair2", RD_ADDR1, 4);
        step();
        step();
        BUS_GNT = 1'b0;
        regs[4] = 8'hA4;
        regs[5] = 8'hB5;
        step();
        checkOutput("t4_req_again", BUS_REQ, 1);
        step();
        BUS_GNT = 1'b1;
        countToValid(n);
        checkOutput("t4_full_rewait", n, 1 + RW + 1);
        waitDone("t4", 1'b0);
        regs[4] = 8'h44;
        regs[5] = 8'h55;

        // Reset while pair 1's odd byte is waiting, then a fresh dump.
        clearCounts();
        applyStimulus();
        waitIdx("t5", 3'd3);
        DOUT_READY = 1'b0;
        RESET = 1'b1;
        step();
        checkResetOutputs("t5_rst");
        RESET = 1'b0;
        DOUT_READY = 1'b1;
        step();
        clearCounts();
        applyStimulus();
        waitDone("t5", 1'b0);

        // START during a dump is ignored.
        clearCounts();
        applyStimulus();
        waitIdx("t6", 3'd2);
        applyStimulus();
        waitDone("t6", 1'b0);
        step();
        step();
        checkOutput("t6_stays_idle", BUSY, 0);

        // Randomized contents, grant and back-pressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            clearCounts();
            applyStimulus();
            waitDone("rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
